// File: rtl/piso_tx.sv
// 7-bit parallel-in / serial-out transmitter: one-word holding register, START strobe,
// LSB-first data bits held CYCLES_PER_BIT+1 clocks each, then a one-clock DONE pulse.
module piso_tx #(
    parameter int unsigned CYCLES_PER_BIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_start,
    output logic       o_data_out,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned DATA_W = 7;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BIT_W  = 3;

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYCLES_PER_BIT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    // One-hot so that corrupted encodings exist and fall into the default arm.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        SHIFT = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   hold_reg;
    logic                hold_full;
    logic [DATA_W-1:0]   shift_reg;
    logic [CNT_W-1:0]    cyc_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic                accept;

    assign o_ready = ~hold_full;
    assign accept  = i_valid & ~hold_full;

    // Outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            shift_reg  <= '0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            o_start    <= 1'b0;
            o_data_out <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg  <= i_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_reg  <= hold_reg;
                        hold_full  <= 1'b0;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= START;
                        o_start    <= 1'b1;
                        o_busy     <= 1'b1;
                        o_data_out <= 1'b0;
                        o_done     <= 1'b0;
                    end
                end

                START: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt    <= '0;
                        state      <= SHIFT;
                        o_start    <= 1'b0;
                        o_data_out <= shift_reg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state      <= DONE;
                            o_done     <= 1'b1;
                            o_data_out <= 1'b0;
                        end else begin
                            o_data_out <= shift_reg[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    o_done     <= 1'b0;
                    o_busy     <= 1'b0;
                    o_data_out <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    cyc_cnt    <= '0;
                    bit_cnt    <= '0;
                    o_start    <= 1'b0;
                    o_data_out <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (CYCLES_PER_BIT 3, 0, 255) checked every cycle against
// a frame-position model, plus directed frames decoded by a bench-side deserializer.
`timescale 1ns/1ps
module tb_piso_tx;

    localparam int NDUT = 3;
    localparam int CPB0 = 3;
    localparam int CPB1 = 0;
    localparam int CPB2 = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] i_data     [NDUT];
    logic       i_valid    [NDUT];
    logic       o_ready    [NDUT];
    logic       o_start    [NDUT];
    logic       o_data_out [NDUT];
    logic       o_busy     [NDUT];
    logic       o_done     [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_tx #(.CYCLES_PER_BIT(CPB0)) u0 (
        .clk(clk), .reset_n(reset_n), .i_data(i_data[0]), .i_valid(i_valid[0]),
        .o_ready(o_ready[0]), .o_start(o_start[0]), .o_data_out(o_data_out[0]),
        .o_busy(o_busy[0]), .o_done(o_done[0]));
    piso_tx #(.CYCLES_PER_BIT(CPB1)) u1 (
        .clk(clk), .reset_n(reset_n), .i_data(i_data[1]), .i_valid(i_valid[1]),
        .o_ready(o_ready[1]), .o_start(o_start[1]), .o_data_out(o_data_out[1]),
        .o_busy(o_busy[1]), .o_done(o_done[1]));
    piso_tx #(.CYCLES_PER_BIT(CPB2)) u2 (
        .clk(clk), .reset_n(reset_n), .i_data(i_data[2]), .i_valid(i_valid[2]),
        .o_ready(o_ready[2]), .o_start(o_start[2]), .o_data_out(o_data_out[2]),
        .o_busy(o_busy[2]), .o_done(o_done[2]));

    function automatic int per(input int k);
        case (k)
            0:       return CPB0 + 1;
            1:       return CPB1 + 1;
            default: return CPB2 + 1;
        endcase
    endfunction

    // Model: position within the frame (-1 = idle); a frame is 8 bit periods plus one DONE clock.
    int         mpos  [NDUT] = '{-1, -1, -1};
    logic [6:0] mword [NDUT] = '{7'd0, 7'd0, 7'd0};
    logic [6:0] mhold [NDUT] = '{7'd0, 7'd0, 7'd0};
    bit         mhv   [NDUT] = '{1'b0, 1'b0, 1'b0};
    bit         m_acc;

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!reset_n) begin
                mpos[k]  = -1;
                mword[k] = 7'd0;
                mhold[k] = 7'd0;
                mhv[k]   = 1'b0;
            end else begin
                m_acc = (i_valid[k] === 1'b1) && !mhv[k];
                if (mpos[k] < 0) begin
                    if (mhv[k]) begin
                        mpos[k]  = 0;
                        mword[k] = mhold[k];
                        mhv[k]   = 1'b0;
                    end
                end else begin
                    mpos[k] = mpos[k] + 1;
                    if (mpos[k] > 8 * per(k)) mpos[k] = -1;
                end
                if (m_acc) begin
                    mhv[k]   = 1'b1;
                    mhold[k] = i_data[k];
                end
            end
        end
    end

    int         c_p;
    logic [4:0] c_exp;
    logic [4:0] c_act;
    logic       c_dat;

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            c_p   = per(k);
            c_dat = (mpos[k] >= c_p && mpos[k] < 8 * c_p) ? mword[k][(mpos[k] - c_p) / c_p] : 1'b0;
            c_exp = {!mhv[k], (mpos[k] >= 0 && mpos[k] < c_p), c_dat, (mpos[k] >= 0),
                     (mpos[k] == 8 * c_p)};
            c_act = {o_ready[k], o_start[k], o_data_out[k], o_busy[k], o_done[k]};
            total = total + 1;
            if (c_act !== c_exp) begin
                bad = bad + 1;
                $display("FAIL cycle dut%0d t=%0t rdy/start/data/busy/done got=%b required=%b",
                         k, $time, c_act, c_exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic accept(input int k, input logic [6:0] w);
        @(negedge clk);
        chk("ready_before_accept", int'(o_ready[k]), 1);
        i_valid[k] = 1'b1;
        i_data[k]  = w;
        @(negedge clk);
        i_valid[k] = 1'b0;
        i_data[k]  = ~w;
    endtask

    // Observes one frame; optionally offers another word (held for inj_len clocks with
    // changing data) starting 3 clocks in. Data samples are decoded mid-bit, like a SIPO.
    task automatic capture(input int k, input bit inj, input logic [6:0] inj_w, input int inj_len,
                           output int n_busy, output int n_start, output int n_done,
                           output int pre_idle, output int n_data, output int unstable,
                           output logic [6:0] rx, output int ready_after_inj);
        logic samp[$];
        int   cyc = 0;
        bit   started = 1'b0;
        bit   fin = 1'b0;
        int   p = per(k);
        n_busy = 0; n_start = 0; n_done = 0; pre_idle = 0; unstable = 0;
        rx = 7'd0; ready_after_inj = -1;
        while (!fin) begin
            @(negedge clk);
            if (o_busy[k] === 1'b1) begin
                started = 1'b1;
                n_busy++;
                if (o_start[k] === 1'b1) n_start++;
                else if (o_done[k] === 1'b1) n_done++;
                else samp.push_back(o_data_out[k]);
            end else if (!started) begin
                pre_idle++;
            end else begin
                fin = 1'b1;
            end
            if (inj && cyc == 4) ready_after_inj = int'(o_ready[k]);
            if (inj && cyc >= 3 && cyc < 3 + inj_len) begin
                i_valid[k] = 1'b1;
                i_data[k]  = inj_w ^ 7'((cyc - 3) * 19);
            end else if (inj && cyc == 3 + inj_len) begin
                i_valid[k] = 1'b0;
            end
            cyc++;
            if (cyc > 5000) begin
                chk("capture_timeout", cyc, 5000);
                fin = 1'b1;
            end
        end
        n_data = samp.size();
        if (n_data == 7 * p) begin
            for (int b = 0; b < 7; b++) begin
                rx[b] = samp[b * p + p / 2];
                for (int j = 0; j < p; j++)
                    if (samp[b * p + j] !== samp[b * p]) unstable++;
            end
        end
    endtask

    int         nb, ns, nd, pi, ndat, un, rai, wt;
    logic [6:0] rx;

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            i_valid[k] = 1'b0;
            i_data[k]  = 7'd0;
        end
        #1;
        for (int k = 0; k < NDUT; k++)
            chk("reset_values", int'({o_ready[k], o_start[k], o_data_out[k], o_busy[k], o_done[k]}),
                int'(5'b10000));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPB=3, 7'h55: 4 start clocks, 7 bits of 4 clocks, 33 busy clocks.
        accept(0, 7'h55);
        capture(0, 1'b0, 7'd0, 0, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("h55_start_clocks", ns, 4);
        chk("h55_busy_clocks", nb, 33);
        chk("h55_done_clocks", nd, 1);
        chk("h55_data_clocks", ndat, 28);
        chk("h55_bit_stable", un, 0);
        chk("h55_word", int'(rx), 'h55);

        // Loopback decode of 7'h2A.
        accept(0, 7'h2A);
        capture(0, 1'b0, 7'd0, 0, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("loopback_2a", int'(rx), 'h2A);

        // CPB=0: 7'h01 then 7'h40 offered mid-frame.
        accept(1, 7'h01);
        capture(1, 1'b1, 7'h40, 1, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("f01_word", int'(rx), 'h01);
        chk("f01_busy_clocks", nb, 9);
        chk("f01_start_clocks", ns, 1);
        chk("ready_low_after_second_accept", rai, 0);
        capture(1, 1'b0, 7'd0, 0, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("f40_word", int'(rx), 'h40);
        chk("idle_gap_one_clock", pi, 0);

        // i_valid held with changing data while full: only the first word is kept.
        accept(0, 7'h0F);
        capture(0, 1'b1, 7'h33, 6, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("f0f_word", int'(rx), 'h0F);
        chk("ready_low_while_full", rai, 0);
        capture(0, 1'b0, 7'd0, 0, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("held_word_33", int'(rx), 'h33);

        // CPB=255, 7'h7F: 256 clocks per bit.
        accept(2, 7'h7F);
        capture(2, 1'b0, 7'd0, 0, nb, ns, nd, pi, ndat, un, rx, rai);
        chk("h7f_start_clocks", ns, 256);
        chk("h7f_data_clocks", ndat, 1792);
        chk("h7f_busy_clocks", nb, 2049);
        chk("h7f_bit_stable", un, 0);
        chk("h7f_word", int'(rx), 'h7F);

        // Reset during the third data bit of 7'h55 with a second word held.
        accept(0, 7'h55);
        wt = 0;
        while (o_busy[0] !== 1'b1 && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chk("abort_frame_started", int'(o_busy[0]), 1);
        @(negedge clk);
        i_valid[0] = 1'b1;
        i_data[0]  = 7'h22;
        @(negedge clk);
        i_valid[0] = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort_bit2_value", int'(o_data_out[0]), 1);
        chk("abort_word_held", int'(o_ready[0]), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({o_ready[0], o_start[0], o_data_out[0], o_busy[0], o_done[0]}),
            int'(5'b10000));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_busy[0] !== 1'b0) nb++;
            if (o_done[0] !== 1'b0) nd++;
        end
        chk("idle_after_abort", nb, 0);
        chk("no_done_after_abort", nd, 0);
        chk("ready_after_abort", int'(o_ready[0]), 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_BIT, default 0, meaning each serial bit is held for CYCLES_PER_BIT+1 clocks (legal range 0..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_data  input  7  parallel word to transmit.
REQ-005 The block SHALL have port i_valid  input  1  i_data is valid this cycle.
REQ-006 The block SHALL have port o_ready  output  1  high when the holding register can accept a word.
REQ-007 The block SHALL have port o_start  output  1  start strobe to the downstream deserializer, high for the whole START bit period.
REQ-008 The block SHALL have port o_data_out  output  1  serial data line.
REQ-009 The block SHALL have port o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port o_done  output  1  single-cycle pulse after the last data bit period.

Function
REQ-011 The block SHALL accept a word on a rising edge where i_valid=1 and o_ready=1, writing i_data into a 7-bit holding register and setting hold_full.
REQ-012 o_ready SHALL equal !hold_full (combinational from registered state); no accept while full; i_data while o_ready=0 is ignored.
REQ-013 The FSM SHALL have states IDLE, START, SHIFT, DONE.
REQ-014 IDLE: on an edge with hold_full=1, the block SHALL load the 7-bit shift register from the holding register, clear hold_full, clear cycle and bit counters, and go to START; otherwise it stays in IDLE.
REQ-015 START: o_start=1 and o_data_out=0 for CYCLES_PER_BIT+1 clocks, then go to SHIFT.
REQ-016 SHIFT: o_data_out SHALL equal shift-register bit 0 (LSB first); when the 8-bit cycle counter equals CYCLES_PER_BIT, the counter resets to 0, the shift register shifts right by one, and the 3-bit bit counter increments; otherwise the cycle counter increments.
REQ-017 SHIFT SHALL exit to DONE on the bit-period boundary where the bit counter equals 6, giving exactly 7 data bit periods.
REQ-018 DONE: o_done=1 and o_data_out=0 for exactly one clock, then go to IDLE unconditionally.
REQ-019 A frame SHALL last (CYCLES_PER_BIT+1)*8 + 1 clocks from entering START to leaving DONE; minimum gap between frames is one IDLE clock.
REQ-020 A new word MAY be accepted into the holding register during START/SHIFT/DONE; it SHALL NOT alter the frame in progress.
REQ-021 o_data_out, o_start, o_done SHALL be 0 in IDLE; o_start SHALL be 0 outside START; o_done SHALL be 0 outside DONE.
REQ-022 Changes to i_data after acceptance SHALL NOT affect the transmitted word.
REQ-023 An undefined state encoding SHALL return to IDLE on the next edge.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, hold_full=0, holding and shift registers=0, counters=0, so o_ready=1, o_start=0, o_data_out=0, o_busy=0, o_done=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame and discard any held word; after release, the block SHALL stay idle until a new accept.

Verification
REQ-026 CYCLES_PER_BIT=3, accept 7'h55 -> o_start high 4 clocks, then o_data_out 1,0,1,0,1,0,1, each held 4 clocks, o_done one-cycle pulse, total 33 busy clocks.
REQ-027 CYCLES_PER_BIT=0, accept 7'h01 then 7'h40 mid-frame -> o_ready low after second accept until its load; frames 1000000 and 0000001 LSB-first, one IDLE clock between.
REQ-028 i_valid held high with hold_full=1, changing i_data -> no extra accept; held value unchanged; transmitted word equals first accepted.
REQ-029 Assert reset_n=0 during third data bit (CYCLES_PER_BIT=3) -> outputs go to reset values asynchronously; no o_done; o_ready=1 after release.
REQ-030 Loopback to SIPO with equal CYCLES_PER_BIT, 7'h2A -> SIPO reports 7'h2A valid.
REQ-031 CYCLES_PER_BIT=255, 7'h7F -> each bit held exactly 256 clocks, no counter overflow.
